piso_tx_scheduler: RTL and testbench
====================================

# piso_tx_scheduler

Round-robin scheduler that shares one `piso` serializer between `R` requesting word sources. It arbitrates among pending requests, drives the serializer's `load`/`parallel_in`, and counts the `W` shift cycles of each frame. It frames the serial stream with `tx_active`/`tx_first`/`tx_src` so downstream logic can sample `serial_out`. It sits directly in front of a `piso #(.N(W))` instance whose `clk`/`reset` are tied to this block's `clk`/`reset`.

## Interface
- `W`, 8: word width; must equal the serializer `N`; W ≥ 2
- `R`, 4: number of requesters; R ≥ 2
- `GAP`, 1: idle cycles inserted after every frame; 0..15

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `req`  in  R  per-requester request; held high with stable data until its `ack`
- `req_data`  in  R*W  word of requester i at `[i*W +: W]`
- `ack`  out  R  one-hot 1-cycle pulse; word of that requester accepted
- `piso_load`  out  1  to serializer `load`
- `piso_data`  out  W  to serializer `parallel_in`
- `tx_active`  out  1  serializer `serial_out` carries a valid frame bit this cycle
- `tx_first`  out  1  current bit is bit 0 (LSB) of a frame
- `tx_src`  out  clog2(R)  requester index of the frame in flight/being loaded
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, LOAD, SHIFT, GAP.
- IDLE:
  - If any `req` bit is set, pick the first set bit searching upward from `ptr`, wrapping mod R.
  - At the edge, capture its word into `hold`, its index into `tx_src`, `ptr <= grant+1 mod R`, go to LOAD.
  - No request: stay in IDLE.
- LOAD (exactly 1 cycle): `piso_load=1`, `piso_data=hold`, `ack[tx_src]=1`; clear `cnt`; go to SHIFT.
- SHIFT (exactly W cycles):
  - `tx_active=1`; `tx_first=1` when `cnt==0`; `piso_load=0`; `cnt` increments.
  - Serializer shifts LSB-first, so `serial_out` = bit `cnt` of `hold`.
  - At `cnt==W-1`: go to GAP if GAP>0, else IDLE.
- GAP: hold for GAP cycles with all strobes low, then go to IDLE.
- Requests are sampled only in IDLE. `req` changes during LOAD, SHIFT or GAP have no effect.
- A requester drops `req` on the cycle after its `ack`. If `req` is still high when the FSM returns to IDLE, it is served again (round-robin still applies).
- `piso_data` always reflects `hold`; it is only meaningful while `piso_load=1`.
- `tx_src` holds its value from grant until the next grant.
- Reset values: state IDLE, `ptr=0`, `hold=0`, `cnt=0`, `tx_src=0`. All outputs are 0.
- Reset mid-frame (any state):
  - The next cycle is IDLE with all outputs 0.
  - The frame is abandoned and no `ack` is issued afterward. If reset arrives during LOAD, the `ack` already shown that cycle stands.
  - The serializer clears on the same reset.

## Timing
- Request seen high at edge e → LOAD (with `ack`) in cycle e+1 → bit 0 in cycle e+2 → bit W-1 in cycle e+W+1.
- Frame period with continuous requests: 1 (IDLE) + 1 (LOAD) + W + GAP cycles.
- `ack` to first valid bit: 1 cycle.
- Exactly one `ack` per frame; `ack` is never asserted outside LOAD.
- `tx_active` is high for exactly W consecutive cycles per frame; `tx_first` is high for one cycle per frame.
- Simultaneous requests are resolved purely by `ptr`. No requester waits more than R-1 frames.

## Test plan
- Reset held 3 cycles with `req=4'b1111` → all outputs 0, `busy=0`; after release, first grant is requester 0.
- W=8, GAP=2: `req[1]=1` with data 0xA5 → 1 cycle later `piso_load=1`, `piso_data=0xA5`, `ack=4'b0010`, `tx_src=1`.
  - The next 8 cycles show `serial_out` = 1,0,1,0,0,1,0,1 with `tx_active=1` and `tx_first` on the first cycle.
  - Then 2 GAP cycles, then IDLE.
- `req[0]` and `req[2]` rise together, data 0x3C and 0xF0 → frame from 0 (0x3C) first, then from 2 (0xF0).
  - Frames start 12 cycles apart; no frame for requesters 1 or 3.
- All four `req` held continuously (re-raised after each `ack`) → grant order 0,1,2,3,0,1.
  - `ack` pulses exactly 12 cycles apart; `tx_src` matches each frame.
- GAP=0 with continuous `req[3]` → frames back-to-back with period 10, one IDLE cycle between the last bit and the next LOAD.
- `reset` pulsed for 1 cycle during SHIFT bit 3 of requester 2's frame → next cycle `tx_active=0`, `busy=0`, no further `ack`.
  - With `req[2]` still high, the next grant goes to requester 0 if it is requesting, else to 2 with a full 8-bit frame.

Source files
------------

// File: rtl/piso_tx_scheduler.sv
// ============================================================================
// piso_tx_scheduler
// ----------------------------------------------------------------------------
// Shares one external `piso #(.N(W))` serializer between R word sources.
// A round-robin arbiter picks one pending request while idle and latches its
// word. The word is then loaded into the serializer for one cycle. The block
// counts the W shift cycles of the frame and can insert GAP idle cycles before
// it looks at requests again. Framing strobes tell downstream logic when the
// serializer's `serial_out` carries a valid bit.
//
// Frame timeline for one grant:
//   IDLE (grant at edge) -> LOAD (1 cycle) -> SHIFT (W cycles) -> GAP (GAP cycles)
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high; clears the FSM and all outputs
//   req        : per-requester request, held with stable data until its ack
//   req_data   : word of requester i at [i*W +: W]
//   ack        : one-hot, one-cycle pulse during LOAD for the granted source
//   piso_load  : serializer load strobe (high during LOAD)
//   piso_data  : serializer parallel input, always the latched word
//   tx_active  : serial_out carries a valid frame bit this cycle
//   tx_first   : current serial bit is bit 0 (LSB) of the frame
//   tx_src     : index of the frame being loaded or shifted
//   busy       : FSM is not idle
// ============================================================================
module piso_tx_scheduler #(
   parameter int W   = 8,
   parameter int R   = 4,
   parameter int GAP = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [R-1:0]         req,
   input  logic [R*W-1:0]       req_data,
   output logic [R-1:0]         ack,
   output logic                 piso_load,
   output logic [W-1:0]         piso_data,
   output logic                 tx_active,
   output logic                 tx_first,
   output logic [$clog2(R)-1:0] tx_src,
   output logic                 busy
);

   localparam int SRC_W = $clog2(R);
   localparam int CNT_W = $clog2(W);
   localparam int GAP_W = 4;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

   // -------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // -------------------------------------------------------------------------
   if (W < 2) begin : g_bad_w
      $error("piso_tx_scheduler: W must be at least 2");
   end
   if (R < 2) begin : g_bad_r
      $error("piso_tx_scheduler: R must be at least 2");
   end
   if (GAP < 0 || GAP > 15) begin : g_bad_gap
      $error("piso_tx_scheduler: GAP must be in 0..15");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_GAP   = 2'd3
   } state_e;

   // Control state
   state_e             state_q, state_d;
   logic [SRC_W-1:0]   ptr_q,   ptr_d;
   logic [SRC_W-1:0]   src_q,   src_d;
   logic [W-1:0]       hold_q,  hold_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [GAP_W-1:0]   gap_q,   gap_d;

   // Registered strobes, computed from the next state so they line up with it
   logic [R-1:0]       ack_q,    ack_d;
   logic               load_q,   load_d;
   logic               active_q, active_d;
   logic               first_q,  first_d;
   logic               busy_q,   busy_d;

   // Arbiter result
   logic               grant_valid;
   logic [SRC_W-1:0]   grant_idx;

   // -------------------------------------------------------------------------
   // Round-robin pick: first set request at or above ptr, wrapping mod R.
   // The !grant_valid guard keeps the earliest hit in search order.
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default before any branch,
      // so no path leaves a signal unassigned and no latch is inferred.
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < R; i++) begin
         if (!grant_valid && req[(int'(ptr_q) + i) % R]) begin
            grant_valid = 1'b1;
            grant_idx   = SRC_W'((int'(ptr_q) + i) % R);
         end
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      src_d   = src_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;

      case (state_q)
         S_IDLE: begin
            // Requests are sampled only here; the word is latched so that a
            // requester changing its data after ack cannot corrupt the frame.
            if (grant_valid) begin
               src_d   = grant_idx;
               hold_d  = req_data[int'(grant_idx)*W +: W];
               ptr_d   = SRC_W'((int'(grant_idx) + 1) % R);
               state_d = S_LOAD;
            end
         end

         S_LOAD: begin
            cnt_d   = '0;
            state_d = S_SHIFT;
         end

         S_SHIFT: begin
            if (cnt_q == CNT_LAST) begin
               gap_d   = '0;
               state_d = (GAP > 0) ? S_GAP : S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Output strobes for the cycle after the edge. Because they are derived
   // from state_d, the registered copies are valid in the same cycle the FSM
   // enters the matching state.
   // -------------------------------------------------------------------------
   always_comb begin
      ack_d    = '0;
      load_d   = (state_d == S_LOAD);
      active_d = (state_d == S_SHIFT);
      // Entering SHIFT from LOAD is the only time cnt_d is zero in SHIFT.
      first_d  = (state_d == S_SHIFT) && (cnt_d == '0);
      busy_d   = (state_d != S_IDLE);
      if (state_d == S_LOAD) begin
         ack_d[src_d] = 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples pre-edge values regardless of evaluation order.
      if (reset) begin
         // NOTE: the latched word is reset as well, because piso_data mirrors
         // it and every output must read zero coming out of reset.
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         src_q    <= '0;
         hold_q   <= '0;
         cnt_q    <= '0;
         gap_q    <= '0;
         ack_q    <= '0;
         load_q   <= 1'b0;
         active_q <= 1'b0;
         first_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         src_q    <= src_d;
         hold_q   <= hold_d;
         cnt_q    <= cnt_d;
         gap_q    <= gap_d;
         ack_q    <= ack_d;
         load_q   <= load_d;
         active_q <= active_d;
         first_q  <= first_d;
         busy_q   <= busy_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign ack       = ack_q;
   assign piso_load = load_q;
   assign piso_data = hold_q;
   assign tx_active = active_q;
   assign tx_first  = first_q;
   assign tx_src    = src_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// ============================================================================
// tb_piso_tx_scheduler
// ----------------------------------------------------------------------------
// Two scheduler instances share clk/reset: dut_a with GAP=2 and dut_b with
// GAP=0. A frame-level model tracks, for each instance, how many cycles have
// passed since the last grant. Every output is derived from that cycle
// position and checked on each falling edge. Small serializer models driven
// by the DUT's load/data reproduce `serial_out`. Directed phases add literal
// expectations on grant order, spacing and bit patterns.
// ============================================================================
module tb_piso_tx_scheduler;

   localparam int W = 8;
   localparam int R = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [R-1:0]   req_a = '0, req_b = '0, keep_a = '0, keep_b = '0;
   logic [R*W-1:0] data_a = '0, data_b = '0;

   logic [R-1:0] ack_a, ack_b;
   logic         load_a, load_b, act_a, act_b, first_a, first_b, busy_a, busy_b;
   logic [W-1:0] pdata_a, pdata_b;
   logic [1:0]   src_a, src_b;

   piso_tx_scheduler #(.W(W), .R(R), .GAP(2)) dut_a (
      .clk(clk), .reset(reset), .req(req_a), .req_data(data_a),
      .ack(ack_a), .piso_load(load_a), .piso_data(pdata_a),
      .tx_active(act_a), .tx_first(first_a), .tx_src(src_a), .busy(busy_a)
   );

   piso_tx_scheduler #(.W(W), .R(R), .GAP(0)) dut_b (
      .clk(clk), .reset(reset), .req(req_b), .req_data(data_b),
      .ack(ack_b), .piso_load(load_b), .piso_data(pdata_b),
      .tx_active(act_b), .tx_first(first_b), .tx_src(src_b), .busy(busy_b)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;

   // Frame-level model: pos = 0 idle, 1 load, 2..W+1 bits, then gap cycles.
   int           m_pos [2] = '{0, 0};
   int           m_ptr [2] = '{0, 0};
   int           m_src [2] = '{0, 0};
   logic [W-1:0] m_hold[2] = '{'0, '0};
   logic [W-1:0] sreg  [2];

   // Observed events
   int           ack_cyc_a[$], ack_src_a[$], ack_cyc_b[$];
   logic [W-1:0] ack_dat_a[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic int gap_of(input int k);
      return (k == 0) ? 2 : 0;
   endfunction

   function automatic int pick(input logic [R-1:0] rq, input int ptr);
      for (int i = 0; i < R; i++) begin
         if (rq[(ptr + i) % R]) return (ptr + i) % R;
      end
      return -1;
   endfunction

   function automatic int onehot_idx(input logic [R-1:0] v);
      for (int i = 0; i < R; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_step(input int k, input logic [R-1:0] rq, input logic [R*W-1:0] dt);
      int g;
      if (reset) begin
         m_pos[k]  = 0;
         m_ptr[k]  = 0;
         m_src[k]  = 0;
         m_hold[k] = '0;
      end else if (m_pos[k] == 0) begin
         g = pick(rq, m_ptr[k]);
         if (g >= 0) begin
            m_src[k]  = g;
            m_hold[k] = dt[g*W +: W];
            m_ptr[k]  = (g + 1) % R;
            m_pos[k]  = 1;
         end
      end else if (m_pos[k] == W + 1 + gap_of(k)) begin
         m_pos[k] = 0;
      end else begin
         m_pos[k] = m_pos[k] + 1;
      end
   endtask

   // Model advance plus serializer models fed by the DUT outputs.
   always @(posedge clk) begin
      cyc = cyc + 1;
      model_step(0, req_a, data_a);
      model_step(1, req_b, data_b);
      sreg[0] = reset ? '0 : (load_a ? pdata_a : (sreg[0] >> 1));
      sreg[1] = reset ? '0 : (load_b ? pdata_b : (sreg[1] >> 1));
   end

   task automatic check_inst(input int k, input logic [R-1:0] ack, input logic load,
                             input logic [W-1:0] pdata, input logic act, input logic first,
                             input logic [1:0] src, input logic busy);
      int           p;
      logic [R-1:0] e_ack;
      logic         e_act;
      p     = m_pos[k];
      e_ack = '0;
      if (p == 1) e_ack[m_src[k]] = 1'b1;
      e_act = (p >= 2) && (p <= W + 1);
      check($sformatf("ack[%0d]", k),       32'(ack),   32'(e_ack));
      check($sformatf("piso_load[%0d]", k), 32'(load),  32'(p == 1));
      check($sformatf("piso_data[%0d]", k), 32'(pdata), 32'(m_hold[k]));
      check($sformatf("tx_active[%0d]", k), 32'(act),   32'(e_act));
      check($sformatf("tx_first[%0d]", k),  32'(first), 32'(p == 2));
      check($sformatf("tx_src[%0d]", k),    32'(src),   32'(m_src[k]));
      check($sformatf("busy[%0d]", k),      32'(busy),  32'(p != 0));
      if (e_act) begin
         check($sformatf("serial_out[%0d]", k), 32'(sreg[k][0]), 32'(m_hold[k][p-2]));
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check_inst(0, ack_a, load_a, pdata_a, act_a, first_a, src_a, busy_a);
         check_inst(1, ack_b, load_b, pdata_b, act_b, first_b, src_b, busy_b);
         if (ack_a != '0) begin
            ack_cyc_a.push_back(cyc);
            ack_src_a.push_back(onehot_idx(ack_a));
            ack_dat_a.push_back(pdata_a);
         end
         if (ack_b != '0) ack_cyc_b.push_back(cyc);
      end
   end

   // One clock: requesters drop req the cycle after their ack unless kept.
   task automatic step();
      logic [R-1:0] sa, sb;
      @(posedge clk);
      sa = ack_a;
      sb = ack_b;
      #1;
      req_a = req_a & ~(sa & ~keep_a);
      req_b = req_b & ~(sb & ~keep_b);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy_a || busy_b || req_a != '0 || req_b != '0) && n < 400) begin
         step();
         n++;
      end
      step();
      check("idle_wait_timeout", 32'(n >= 400), 32'(0));
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      step();
      reset = 1'b0;
      ack_cyc_a.delete();
      ack_src_a.delete();
      ack_dat_a.delete();
      ack_cyc_b.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int exp_bits[8];
      int exp_order[6];
      int n;
      exp_bits  = '{1, 0, 1, 0, 0, 1, 0, 1};
      exp_order = '{0, 1, 2, 3, 0, 1};

      // ---- Reset held 3 cycles with every request high ----
      req_a  = 4'b1111;
      data_a = {8'h44, 8'h33, 8'h22, 8'h11};
      step();
      chk_en = 1'b1;
      step();
      step();
      check("rst_busy", 32'(busy_a), 32'(0));
      check("rst_ack",  32'(ack_a),  32'(0));
      check("rst_data", 32'(pdata_a), 32'(0));
      reset = 1'b0;
      step();
      check("first_grant_ack", 32'(ack_a), 32'(4'b0001));
      req_a = '0;
      wait_idle();

      // ---- Single request from requester 1, word 0xA5 ----
      data_a = {8'h00, 8'h00, 8'hA5, 8'h00};
      req_a  = 4'b0010;
      step();
      check("a5_load",  32'(load_a),  32'(1));
      check("a5_data",  32'(pdata_a), 32'(8'hA5));
      check("a5_ack",   32'(ack_a),   32'(4'b0010));
      check("a5_src",   32'(src_a),   32'(1));
      for (int i = 0; i < 8; i++) begin
         step();
         check($sformatf("a5_active%0d", i), 32'(act_a),      32'(1));
         check($sformatf("a5_first%0d", i),  32'(first_a),    32'(i == 0));
         check($sformatf("a5_bit%0d", i),    32'(sreg[0][0]), 32'(exp_bits[i]));
      end
      step();
      check("a5_gap1_busy",   32'(busy_a), 32'(1));
      check("a5_gap1_active", 32'(act_a),  32'(0));
      step();
      check("a5_gap2_busy",   32'(busy_a), 32'(1));
      step();
      check("a5_idle_busy",   32'(busy_a), 32'(0));

      // ---- Requesters 0 and 2 together ----
      reset_pulse();
      data_a = {8'h00, 8'hF0, 8'h00, 8'h3C};
      req_a  = 4'b0101;
      repeat (30) step();
      check("pair_count", 32'(ack_src_a.size()), 32'(2));
      if (ack_src_a.size() >= 2) begin
         check("pair_src0",   32'(ack_src_a[0]), 32'(0));
         check("pair_src1",   32'(ack_src_a[1]), 32'(2));
         check("pair_dat0",   32'(ack_dat_a[0]), 32'(8'h3C));
         check("pair_dat1",   32'(ack_dat_a[1]), 32'(8'hF0));
         check("pair_period", 32'(ack_cyc_a[1] - ack_cyc_a[0]), 32'(12));
      end

      // ---- All four requesting continuously ----
      reset_pulse();
      data_a = {8'h81, 8'h7E, 8'h0F, 8'hC3};
      req_a  = 4'b1111;
      keep_a = 4'b1111;
      n = 0;
      while (ack_src_a.size() < 6 && n < 200) begin
         step();
         n++;
      end
      req_a  = '0;
      keep_a = '0;
      wait_idle();
      check("rr_count", 32'(ack_src_a.size()), 32'(6));
      if (ack_src_a.size() >= 6) begin
         for (int i = 0; i < 6; i++) begin
            check($sformatf("rr_src%0d", i), 32'(ack_src_a[i]), 32'(exp_order[i]));
         end
         for (int i = 1; i < 6; i++) begin
            check($sformatf("rr_period%0d", i), 32'(ack_cyc_a[i] - ack_cyc_a[i-1]), 32'(12));
         end
      end

      // ---- GAP=0 instance, continuous requester 3 ----
      data_b = {8'h96, 8'h00, 8'h00, 8'h00};
      req_b  = 4'b1000;
      keep_b = 4'b1000;
      n = 0;
      while (ack_cyc_b.size() < 4 && n < 200) begin
         step();
         n++;
      end
      req_b  = '0;
      keep_b = '0;
      wait_idle();
      check("b2b_count", 32'(ack_cyc_b.size()), 32'(4));
      if (ack_cyc_b.size() >= 4) begin
         for (int i = 1; i < 4; i++) begin
            check($sformatf("b2b_period%0d", i), 32'(ack_cyc_b[i] - ack_cyc_b[i-1]), 32'(10));
         end
      end

      // ---- Reset during bit 3 of requester 2, only 2 requesting ----
      reset_pulse();
      data_a = {8'h00, 8'h5A, 8'h00, 8'hE7};
      req_a  = 4'b0100;
      keep_a = 4'b0100;
      step();
      check("rsta_ack", 32'(ack_a), 32'(4'b0100));
      repeat (4) step();
      check("rsta_in_frame", 32'(act_a), 32'(1));
      reset = 1'b1;
      step();
      check("rsta_post_active", 32'(act_a),  32'(0));
      check("rsta_post_busy",   32'(busy_a), 32'(0));
      check("rsta_post_ack",    32'(ack_a),  32'(0));
      reset = 1'b0;
      step();
      check("rsta_regrant", 32'(ack_a), 32'(4'b0100));
      keep_a = '0;
      wait_idle();
      check("rsta_count", 32'(ack_src_a.size()), 32'(2));

      // ---- Same, but requester 0 joins during the reset ----
      ack_src_a.delete();
      req_a  = 4'b0100;
      keep_a = 4'b0100;
      step();
      check("rstb_ack", 32'(ack_a), 32'(4'b0100));
      repeat (4) step();
      reset = 1'b1;
      req_a = 4'b0101;
      step();
      check("rstb_post_busy", 32'(busy_a), 32'(0));
      reset  = 1'b0;
      keep_a = '0;
      step();
      check("rstb_regrant", 32'(ack_a), 32'(4'b0001));
      wait_idle();
      check("rstb_count", 32'(ack_src_a.size()), 32'(3));
      if (ack_src_a.size() >= 3) begin
         check("rstb_last_src", 32'(ack_src_a[2]), 32'(2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
